multicycle_ctrl_fsm: RTL
========================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Control FSM for the multicycle RV32I core. Sequences the shared ALU, memory port, IR and register file
//  across FETCH/DECODE/EXECUTE/WB states. Supports the opcode set lw, sw, R, I-ALU, beq, jal and jalr.
//  Stalls on a memory-ready handshake. Sits beside the existing ALU decoder, which consumes ALUOp.
// PARAMETERS
//  ILLEGAL_HALT  0  1: an illegal opcode parks the FSM in ERROR until reset. 0: ERROR returns to FETCH after 1 cycle.
// PORTS
//  clk          in   1  core clock, rising edge
//  rst_n        in   1  asynchronous active-low reset
//  op           in   7  opcode field of IR (instr[6:0])
//  zero         in   1  ALU zero flag, same cycle
//  mem_ready    in   1  memory completes the current access this cycle
//  mem_req      out  1  memory access request (FETCH, MEMREAD, MEMWRITE)
//  MemWrite     out  1  store enable
//  AdrSrc       out  1  memory address select: 0=PC, 1=Result
//  IRWrite      out  1  load IR and OldPC
//  PCWrite      out  1  PC load enable = PCUpdate | (Branch & zero)
//  RegWrite     out  1  register-file write enable
//  ResultSrc    out  2  00=ALUOut, 01=Data, 10=ALUResult
//  ALUSrcA      out  2  00=PC, 01=OldPC, 10=A
//  ALUSrcB      out  2  00=B, 01=Imm, 10=const 4
//  ALUOp        out  2  00=add, 01=sub/compare, 10=funct-decoded
//  ImmSrc       out  2  00=I, 01=S, 10=B, 11=J (combinational from op, every state)
//  illegal_op   out  1  high while in ERROR
//  instr_done   out  1  1-cycle pulse on the final cycle of each retired instruction
// BEHAVIOUR
//  State register only; all controls are Moore decodes of state, except PCWrite (uses zero) and the
//   mem_ready gating described below.
//  Reset (async, rst_n=0): state<=FETCH. While rst_n=0, force mem_req, MemWrite, IRWrite, PCWrite,
//   RegWrite, instr_done and illegal_op to 0; muxes take FETCH values. First fetch starts on the first edge after release.
//  Unlisted controls are 0 (selects 00).
//  FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
//   If mem_ready=0: hold FETCH with IRWrite=0, PCUpdate=0.
//   If mem_ready=1: IRWrite=1, PCUpdate=1 (PC<=PC+4), ->DECODE.
//  DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (ALUOut<=OldPC+imm).
//   Next state by op: 0000011/0100011 ->MEMADR; 0110011 ->EXECR; 0010011 ->EXECI; 1100011 ->BEQ;
//   1101111 ->JAL; 1100111 ->JALR1; any other ->ERROR.
//  MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. lw ->MEMREAD; sw ->MEMWRITE.
//  MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00. Hold until mem_ready, then ->MEMWB.
//  MEMWB: ResultSrc=01, RegWrite=1, instr_done=1. ->FETCH.
//  MEMWRITE: mem_req=1, MemWrite=1, AdrSrc=1. Both held while waiting.
//   On mem_ready: instr_done=1, ->FETCH.
//  EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. ->ALUWB.
//  EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. ->ALUWB.
//  ALUWB: ResultSrc=00, RegWrite=1, instr_done=1. ->FETCH.
//  BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, instr_done=1.
//   PCWrite=zero (target from DECODE ALUOut). ->FETCH.
//  JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 (PC<=target, ALUOut<=OldPC+4). ->ALUWB.
//  JALR1: ALUSrcA=10, ALUSrcB=01, ALUOp=00 (ALUOut<=rs1+imm). ->JALR2.
//  JALR2: ResultSrc=00, PCUpdate=1, ALUSrcA=01, ALUSrcB=10, ALUOp=00 (ALUOut<=OldPC+4). ->ALUWB.
//  ERROR: illegal_op=1, no write enables asserted. ILLEGAL_HALT=1: stay. ILLEGAL_HALT=0: ->FETCH.
//  Latency in cycles with mem_ready tied 1: lw 5, sw 4, R/I 4, beq 3, jal 4, jalr 5.
//   Each stall cycle adds 1.
//  Unencoded state value (SEU/X): treat as ERROR.
//  mem_ready outside FETCH/MEMREAD/MEMWRITE is ignored.
// STRUCTURE
//  Shared package riscv_ctrl_pkg: state encodings (4-bit), opcode constants (OP_LOAD, OP_STORE, OP_R,
//   OP_IMM, OP_BRANCH, OP_JAL, OP_JALR), ResultSrc/ALUSrcA/ALUSrcB/ALUOp/ImmSrc select codes.
//  One sub-module, mc_ctrl_decode: pure combinational state+op -> control word.
//  Top holds the state register, next-state logic, mem_ready gating and PCWrite.
// TESTING
//  Reset with rst_n=0 mid-MEMWRITE: MemWrite/mem_req drop to 0 asynchronously (same cycle).
//   After release, state=FETCH.
//  mem_ready=1; lw (op=0000011): FETCH,DECODE,MEMADR,MEMREAD,MEMWB.
//   RegWrite=1 only in cycle 5 with ResultSrc=01. instr_done pulses once.
//  sw with mem_ready low 3 cycles in MEMWRITE: MemWrite=1 for 4 cycles, instr_done only on the ready cycle.
//   IRWrite=0 throughout.
//  beq with zero=1 -> PCWrite=1 in BEQ. Same with zero=0 -> PCWrite=0. Both return to FETCH.
//  jal then jalr: PCUpdate in JAL/JALR2; ALUWB follows with RegWrite=1, ResultSrc=00.
//   Cycle counts are 4 and 5.
//  op=1111111: ERROR with illegal_op=1. ILLEGAL_HALT=0 -> FETCH next cycle. ILLEGAL_HALT=1 -> held for 10+ cycles.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes,
// datapath mux select codes and the decoded control word.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StBeq      = 4'd9,
        StJal      = 4'd10,
        StJalr1    = 4'd11,
        StJalr2    = 4'd12,
        StError    = 4'd13
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // *_rdy fields only take effect in a cycle where mem_ready is high.
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write_rdy;
        logic       pc_update;
        logic       pc_update_rdy;
        logic       branch;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal_op;
        logic       instr_done;
        logic       instr_done_rdy;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Pure combinational decode of FSM state (and opcode for ImmSrc) into the
// control word; handshake gating is applied by the parent.
module mc_ctrl_decode
    import riscv_ctrl_pkg::*;
(
    input  state_e     state,
    input  logic [6:0] op,
    output ctrl_t      ctrl,
    output logic [1:0] imm_src
);

    always_comb begin
        ctrl = '0;
        case (state)
            StFetch: begin
                ctrl.mem_req       = 1'b1;
                ctrl.alu_src_b     = SRCB_FOUR;
                ctrl.result_src    = RES_ALURESULT;
                ctrl.ir_write_rdy  = 1'b1;
                ctrl.pc_update_rdy = 1'b1;
            end
            StDecode: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
            end
            StMemAdr, StJalr1: begin
                ctrl.alu_src_a = SRCA_A;
                ctrl.alu_src_b = SRCB_IMM;
            end
            StMemRead: begin
                ctrl.mem_req = 1'b1;
                ctrl.adr_src = 1'b1;
            end
            StMemWb: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            StMemWrite: begin
                ctrl.mem_req        = 1'b1;
                ctrl.mem_write      = 1'b1;
                ctrl.adr_src        = 1'b1;
                ctrl.instr_done_rdy = 1'b1;
            end
            StExecR: begin
                ctrl.alu_src_a = SRCA_A;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            StExecI: begin
                ctrl.alu_src_a = SRCA_A;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            StAluWb: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            StBeq: begin
                ctrl.alu_src_a  = SRCA_A;
                ctrl.alu_src_b  = SRCB_B;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.branch     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            StJal, StJalr2: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.pc_update = 1'b1;
            end
            // StError and any unencoded (upset) state value.
            default: ctrl.illegal_op = 1'b1;
        endcase
    end

    always_comb begin
        case (op)
            OP_STORE:  imm_src = IMM_S;
            OP_BRANCH: imm_src = IMM_B;
            OP_JAL:    imm_src = IMM_J;
            default:   imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I control FSM: state register, next-state logic, memory
// handshake gating and PCWrite generation around mc_ctrl_decode.
module multicycle_ctrl_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       illegal_op,
    output logic       instr_done
);

    state_e state_q, state_d;
    ctrl_t  ctrl;
    logic   pc_update;

    mc_ctrl_decode u_decode (
        .state   (state_q),
        .op      (op),
        .ctrl    (ctrl),
        .imm_src (ImmSrc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:    if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = StMemAdr;
                    OP_R:              state_d = StExecR;
                    OP_IMM:            state_d = StExecI;
                    OP_BRANCH:         state_d = StBeq;
                    OP_JAL:            state_d = StJal;
                    OP_JALR:           state_d = StJalr1;
                    default:           state_d = StError;
                endcase
            end
            StMemAdr:   state_d = (op == OP_STORE) ? StMemWrite : StMemRead;
            StMemRead:  if (mem_ready) state_d = StMemWb;
            StMemWrite: if (mem_ready) state_d = StFetch;
            StMemWb, StAluWb, StBeq: state_d = StFetch;
            StExecR, StExecI, StJal, StJalr2: state_d = StAluWb;
            StJalr1:    state_d = StJalr2;
            default:    state_d = ILLEGAL_HALT ? StError : StFetch;
        endcase
    end

    // Enables are masked by rst_n so they drop the instant reset asserts.
    always_comb begin
        pc_update  = ctrl.pc_update | (ctrl.pc_update_rdy & mem_ready);
        mem_req    = rst_n & ctrl.mem_req;
        MemWrite   = rst_n & ctrl.mem_write;
        IRWrite    = rst_n & ctrl.ir_write_rdy & mem_ready;
        PCWrite    = rst_n & (pc_update | (ctrl.branch & zero));
        RegWrite   = rst_n & ctrl.reg_write;
        instr_done = rst_n & (ctrl.instr_done | (ctrl.instr_done_rdy & mem_ready));
        illegal_op = rst_n & ctrl.illegal_op;
        AdrSrc     = ctrl.adr_src;
        ResultSrc  = ctrl.result_src;
        ALUSrcA    = ctrl.alu_src_a;
        ALUSrcB    = ctrl.alu_src_b;
        ALUOp      = ctrl.alu_op;
    end

endmodule
